// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one combinational logic unit with a built-in result checker
module logic_unit_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int SETTLE_CYC = 1,
  parameter bit CHECK_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [3*NUM_REQ-1:0] req_abc,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [1:0]           rsp_xy,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic                 unit_a,
  output logic                 unit_b,
  output logic                 unit_c,
  input  logic                 unit_x,
  input  logic                 unit_y,
  output logic                 busy,
  output logic                 mismatch_err
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [GW-1:0] rr_ptr, gid, grant;
  logic [CW-1:0] cnt;
  logic [2:0] op_reg;
  logic any_valid, accept, done, hs_rsp;
  function automatic logic [GW-1:0] wrap(input int v);
    return GW'(v >= NUM_REQ ? v - NUM_REQ : v);
  endfunction
  function automatic logic [1:0] model(input logic [2:0] abc);
    return {~abc[0] ^ (abc[2] | abc[1]), abc[2] & abc[1]};
  endfunction
  // scan from the farthest offset down so the requester nearest rr_ptr wins
  always_comb begin
    grant = rr_ptr;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[wrap(int'(rr_ptr) + k)]) begin
        grant = wrap(int'(rr_ptr) + k);
        any_valid = 1'b1;
      end
  end
  assign accept = state == IDLE && any_valid;
  assign done = state == WAIT && cnt == '0;
  assign hs_rsp = state == RESP && rsp_ready[gid];
  assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;
  assign rsp_valid = state == RESP ? (NUM_REQ'(1) << gid) : '0;
  assign busy = state != IDLE;
  assign {unit_a, unit_b, unit_c} = op_reg;
  always_comb begin
    state_n = state;
    if (accept) state_n = WAIT;
    if (done) state_n = RESP;
    if (hs_rsp) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr <= '0;
      gid <= '0;
      cnt <= '0;
      op_reg <= '0;
      rsp_xy <= '0;
      mismatch_err <= 1'b0;
    end else begin
      if (accept) begin
        op_reg <= req_abc[3*grant +: 3];
        gid <= grant;
        cnt <= CW'(SETTLE_CYC - 1);
      end
      if (state == WAIT && cnt != '0) cnt <= cnt - CW'(1);
      if (done) begin
        rsp_xy <= {unit_x, unit_y};
        if (CHECK_EN && {unit_x, unit_y} != model(op_reg)) mismatch_err <= 1'b1;
      end
      if (hs_rsp) rr_ptr <= wrap(int'(gid) + 1);
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed stimulus with a scoreboard-driven response monitor
module tb_logic_unit_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, stuck_x = 1'b0;
  logic [N-1:0] req_valid = '0, rsp_ready = '0, req_ready, rsp_valid;
  logic [3*N-1:0] req_abc = '0;
  logic [1:0] rsp_xy;
  logic unit_a, unit_b, unit_c, unit_x, unit_y, busy, mismatch_err, seen;
  int checks = 0, failures = 0, rsp_cnt = 0, exp_rsp = 0;
  typedef struct {int id; logic [1:0] xy;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [1:0] tbl [8] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11};
  always #5 clk = ~clk;
  assign unit_x = stuck_x ? 1'b0 : (~unit_c ^ (unit_a | unit_b));
  assign unit_y = unit_a & unit_b;
  logic_unit_arbiter #(.NUM_REQ(N), .SETTLE_CYC(1), .CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_abc(req_abc),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_xy(rsp_xy), .rsp_ready(rsp_ready),
    .unit_a(unit_a), .unit_b(unit_b), .unit_c(unit_c), .unit_x(unit_x), .unit_y(unit_y),
    .busy(busy), .mismatch_err(mismatch_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst_n && (rsp_valid & rsp_ready) != '0) begin
      rsp_cnt++;
      if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("rsp_route", 32'(rsp_valid), 32'(1) << e.id);
        chk("rsp_xy", 32'(rsp_xy), 32'(e.xy));
      end
    end
  task automatic send(input int id, input logic [2:0] abc);
    req_abc[3*id +: 3] = abc;
    req_valid[id] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (req_ready[id]) break;
    end
    chk("req_ready_grant", 32'(req_ready), 32'(1) << id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask
  task automatic wait_rsp(input int target);
    for (int n = 0; n < 50 && rsp_cnt < target; n++) begin
      @(posedge clk); #1;
    end
    chk("rsp_timeout", 32'(rsp_cnt < target), 32'd0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_xy", 32'(rsp_xy), 32'd0);
    chk("rst_unit_abc", 32'({unit_a, unit_b, unit_c}), 32'd0);
    chk("rst_mismatch", 32'(mismatch_err), 32'd0);
    @(posedge clk); #1;
    rsp_ready = '1;
    sb.push_back('{2, 2'b01});
    send(2, 3'b110);
    @(negedge clk);
    chk("latency_t1_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("latency_t2_rsp_valid", 32'(rsp_valid), 32'b0100);
    chk("latency_t2_rsp_xy", 32'(rsp_xy), 32'b01);
    wait_rsp(++exp_rsp);
    for (int v = 0; v < 8; v++) begin
      sb.push_back('{0, tbl[v]});
      send(0, 3'(v));
      wait_rsp(++exp_rsp);
    end
    chk("sweep_mismatch", 32'(mismatch_err), 32'd0);
    do_reset();
    req_abc = {3'b111, 3'b110, 3'b011, 3'b001};
    sb.push_back('{0, tbl[1]});
    sb.push_back('{1, tbl[3]});
    sb.push_back('{2, tbl[6]});
    sb.push_back('{3, tbl[7]});
    sb.push_back('{0, tbl[1]});
    req_valid = '1;
    exp_rsp += 5;
    wait_rsp(exp_rsp);
    req_valid = '0;
    chk("rr_sb_drained", 32'(sb.size()), 32'd0);
    rsp_ready = 4'b1101;
    sb.push_back('{1, tbl[3]});
    send(1, 3'b011);
    req_valid[3] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid[1]) break;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'b0010);
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'b0010);
      chk("bp_rsp_xy", 32'(rsp_xy), 32'b10);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    rsp_ready[1] = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1010;
    exp_rsp++;
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_rr_ptr_grant", 32'(req_ready), 32'b1000);
    req_valid = '0;
    @(posedge clk); #1;
    chk("bp_rsp_count", 32'(rsp_cnt), 32'(exp_rsp));
    stuck_x = 1'b1;
    sb.push_back('{0, 2'b00});
    send(0, 3'b000);
    wait_rsp(++exp_rsp);
    chk("fault_mismatch", 32'(mismatch_err), 32'd1);
    stuck_x = 1'b0;
    sb.push_back('{0, tbl[5]});
    send(0, 3'b101);
    wait_rsp(++exp_rsp);
    chk("mismatch_sticky", 32'(mismatch_err), 32'd1);
    send(0, 3'b111);
    chk("midwait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_unit", 32'({unit_a, unit_b, unit_c}), 32'd0);
    chk("async_rst_mismatch", 32'(mismatch_err), 32'd0);
    chk("async_rst_rsp_xy", 32'(rsp_xy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen |= |rsp_valid;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'd0);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
